// File: rtl/seq_multiplier_n_bit_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package seq_multiplier_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/seq_multiplier_n_bit_if.sv
// Start/done request bus between a controller (master) and the multiplier (slave).
interface seq_multiplier_n_bit_if #(
   parameter int DATA_WIDTH = seq_multiplier_pkg::DEFAULT_DATA_WIDTH
);
   import seq_multiplier_pkg::*;

   logic                      Start_In;
   logic                      Signed_Mode_In;
   logic [DATA_WIDTH-1:0]     Data_A_In;
   logic [DATA_WIDTH-1:0]     Data_B_In;
   logic                      Busy_Out;
   logic                      Done_Out;
   logic [2*DATA_WIDTH-1:0]   Multiplied_Result_Out;

   modport master (
      output Start_In, Signed_Mode_In, Data_A_In, Data_B_In,
      input  Busy_Out, Done_Out, Multiplied_Result_Out
   );

   modport slave (
      input  Start_In, Signed_Mode_In, Data_A_In, Data_B_In,
      output Busy_Out, Done_Out, Multiplied_Result_Out
   );

endinterface

// File: rtl/seq_multiplier_n_bit_abs.sv
// Operand conditioning: magnitude and sign of an N-bit value, two's-complement only when signed_en.
module twos_complement_abs
   import seq_multiplier_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic signed [DATA_WIDTH-1:0] value,
   input  logic                         signed_en,
   output logic        [DATA_WIDTH-1:0] magnitude,
   output logic                         sign
);

   // The most negative value negates to itself, which read unsigned is 2^(N-1).
   assign sign      = signed_en & value[DATA_WIDTH-1];
   assign magnitude = sign ? $unsigned(-value) : $unsigned(value);

endmodule

// File: rtl/seq_multiplier_n_bit.sv
// N-bit sequential shift-add multiplier, one partial product per clock, start/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_multiplier_n_bit
   import seq_multiplier_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  Clock_In,
   input  logic                  Reset_In,
   seq_multiplier_n_bit_if.slave bus
);

   localparam int N     = DATA_WIDTH;
   localparam int CNT_W = $clog2(N + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               sign_flag;
   logic [N-1:0]       mcand;
   logic [N-1:0]       mplier;
   logic [2*N-1:0]     acc;

   logic [N-1:0]       a_mag, b_mag;
   logic               a_sign, b_sign;
   logic               accept;

   logic [N:0]         upper_sum;
   logic [2*N-1:0]     acc_step;
   logic [N-1:0]       mplier_step;
   logic [CNT_W-1:0]   cnt_step;
   logic               run_last;
   logic [2*N-1:0]     product;

   function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] value, input logic neg);
      return neg ? (~value + {{(2*N-1){1'b0}}, 1'b1}) : value;
   endfunction

   twos_complement_abs #(.DATA_WIDTH(N)) u_abs_a (
      .value     (bus.Data_A_In),
      .signed_en (bus.Signed_Mode_In),
      .magnitude (a_mag),
      .sign      (a_sign)
   );

   twos_complement_abs #(.DATA_WIDTH(N)) u_abs_b (
      .value     (bus.Data_B_In),
      .signed_en (bus.Signed_Mode_In),
      .magnitude (b_mag),
      .sign      (b_sign)
   );

   assign accept = ((state == IDLE) || (state == DONE)) && bus.Start_In;

   // One shift-add step: carry out of the upper half lands in the MSB after the shift.
   always_comb begin
      upper_sum = {1'b0, acc[2*N-1:N]};
      if (mplier[0]) begin
         upper_sum = upper_sum + {1'b0, mcand};
      end
      acc_step    = {upper_sum, acc[N-1:1]};
      mplier_step = mplier >> 1;
      cnt_step    = cnt + CNT_W'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
      run_last = (cnt_step == CNT_W'(N)) || (mplier_step == '0);
      product  = acc_step >> (CNT_W'(N) - cnt_step);
`else
      run_last = (cnt_step == CNT_W'(N));
      product  = acc_step;
`endif
   end

   // Control and outputs
   always_ff @(posedge Clock_In or negedge Reset_In) begin
      if (!Reset_In) begin
         state                     <= IDLE;
         cnt                       <= '0;
         sign_flag                 <= 1'b0;
         bus.Busy_Out              <= 1'b0;
         bus.Done_Out              <= 1'b0;
         bus.Multiplied_Result_Out <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.Done_Out <= 1'b0;
               if (bus.Start_In) begin
                  state        <= RUN;
                  bus.Busy_Out <= 1'b1;
                  cnt          <= '0;
                  sign_flag    <= a_sign ^ b_sign;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               cnt <= cnt_step;
               if (run_last) begin
                  state                     <= DONE;
                  bus.Busy_Out              <= 1'b0;
                  bus.Done_Out              <= 1'b1;
                  bus.Multiplied_Result_Out <= apply_sign(product, sign_flag);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath registers hold no state that matters outside RUN
   always_ff @(posedge Clock_In) begin
      if (accept) begin
         mcand  <= a_mag;
         mplier <= b_mag;
         acc    <= '0;
      end else if (state == RUN) begin
         acc    <= acc_step;
         mplier <= mplier_step;
      end
   end

endmodule

// File: tb/tb_seq_multiplier_n_bit.sv
// Scoreboard bench for seq_multiplier_n_bit (N=8); expected latency follows SEQ_MULT_EARLY_TERM_EN.
module tb_seq_multiplier_n_bit;
   import seq_multiplier_pkg::*;

   localparam int N = 8;

   typedef struct {
      logic [2*N-1:0] res;
      int             done_cyc;
      int             lat;
      string          name;
   } exp_t;

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic           s;
      logic [2*N-1:0] res;
      string          name;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   busy_run = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_multiplier_n_bit_if #(.DATA_WIDTH(N)) bus ();

   seq_multiplier_n_bit #(.DATA_WIDTH(N)) dut (
      .Clock_In (clk),
      .Reset_In (rst_n),
      .bus      (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int exp_lat(input logic [N-1:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
      logic [N-1:0] mag;
      int hi;
      mag = (s && b[N-1]) ? (~b + 1'b1) : b;
      hi = 0;
      for (int i = 0; i < N; i++) if (mag[i]) hi = i;
      return hi + 1;
`else
      return N + (b & 0) + (s & 0);
`endif
   endfunction

   // Issue a request; it is sampled at the next rising edge.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input logic [2*N-1:0] res, input string name);
      exp_t e;
      bus.Start_In       = 1'b1;
      bus.Data_A_In      = a;
      bus.Data_B_In      = b;
      bus.Signed_Mode_In = s;
      @(posedge clk);
      #1;
      e.res      = res;
      e.lat      = exp_lat(b, s);
      e.done_cyc = cyc + e.lat;
      e.name     = name;
      sb_q.push_back(e);
      bus.Start_In = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      check({name, "_drain"}, 64'(sb_q.size()), 64'd0);
   endtask

   // Monitor: compare every Done_Out pulse against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (bus.Busy_Out) busy_run++;
         if (bus.Done_Out) begin
            check("done_has_request", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               check({mon_e.name, "_result"}, 64'(bus.Multiplied_Result_Out), 64'(mon_e.res));
               check({mon_e.name, "_done_cycle"}, 64'(cyc), 64'(mon_e.done_cyc));
               check({mon_e.name, "_busy_cycles"}, 64'(busy_run), 64'(mon_e.lat));
            end
            check("busy_low_at_done", 64'(bus.Busy_Out), 64'd0);
            busy_run = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.Start_In       = 1'b0;
      bus.Signed_Mode_In = 1'b0;
      bus.Data_A_In      = '0;
      bus.Data_B_In      = '0;

      vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff"});
      vecs.push_back('{8'hF9, 8'h03, 1'b1, 16'hFFEB, "s_m7_3"});
      vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000, "s_min_min"});
      vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080, "s_max_min"});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1_m1"});
      vecs.push_back('{8'h05, 8'hFB, 1'b1, 16'hFFE7, "s_5_m5"});
      vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000, "u_80_80"});
      vecs.push_back('{8'h11, 8'h00, 1'b0, 16'h0000, "u_b_zero"});
      vecs.push_back('{8'h0C, 8'h05, 1'b0, 16'h003C, "u_12_5"});
      vecs.push_back('{8'h03, 8'h80, 1'b0, 16'h0180, "u_3_128"});

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(bus.Busy_Out), 64'd0);
      check("reset_done", 64'(bus.Done_Out), 64'd0);
      check("reset_result", 64'(bus.Multiplied_Result_Out), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].name);
         drain(vecs[i].name);
      end

      // Back-to-back: Start stays high across the first Done_Out.
      issue(8'd12, 8'd10, 1'b0, 16'd120, "b2b_first");
      bus.Start_In  = 1'b1;
      bus.Data_A_In = 8'd5;
      bus.Data_B_In = 8'd5;
      for (int i = 0; i < 40 && !bus.Done_Out; i++) @(negedge clk);
      check("b2b_first_done_seen", 64'(bus.Done_Out), 64'd1);
      issue(8'd5, 8'd5, 1'b0, 16'd25, "b2b_second");
      drain("b2b");

      // Start pulse during RUN must be ignored.
      issue(8'd6, 8'd7, 1'b0, 16'd42, "ign");
`ifdef SEQ_MULT_EARLY_TERM_EN
      repeat (1) @(posedge clk);
`else
      repeat (3) @(posedge clk);
`endif
      #1;
      bus.Start_In  = 1'b1;
      bus.Data_A_In = 8'd3;
      bus.Data_B_In = 8'd3;
      @(posedge clk);
      #1;
      bus.Start_In = 1'b0;
      drain("ign");
      repeat (12) @(negedge clk);
      check("ign_no_restart", 64'(bus.Busy_Out), 64'd0);

      // Reset in the middle of RUN.
      bus.Start_In       = 1'b1;
      bus.Data_A_In      = 8'h55;
      bus.Data_B_In      = 8'h33;
      bus.Signed_Mode_In = 1'b0;
      @(posedge clk);
      #1;
      bus.Start_In = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_busy_before", 64'(bus.Busy_Out), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 64'(bus.Busy_Out), 64'd0);
      check("rst_mid_done", 64'(bus.Done_Out), 64'd0);
      check("rst_mid_result", 64'(bus.Multiplied_Result_Out), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(8'd2, 8'd9, 1'b0, 16'd18, "after_rst");
      drain("after_rst");

      repeat (5) @(negedge clk);
      check("queue_empty_end", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
